// File: rtl/case_9_sdiv_10s_4s_seq.sv
// Multi-cycle signed divider (10-bit dividend / 4-bit divisor): radix-2 restoring
// division on magnitudes, one quotient bit per clock, valid/ready on both sides.
module case_9_sdiv_10s_4s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 10
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_zero,
    output logic                  ovf
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = $clog2(W0 + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [W0-1:0]         dvd_q, dvd_d;
    logic [W1-1:0]         dvs_q, dvs_d;
    logic [W1:0]           prem_q, prem_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sign0_q, sign0_d;
    logic                  sign1_q, sign1_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic [W1-1:0]         rem_q, rem_d;
    logic                  div_zero_q, div_zero_d;
    logic                  ovf_q, ovf_d;

    logic [W0-1:0] mag0;
    logic [W1-1:0] mag1;
    logic [W1+1:0] shifted;
    logic [W1+1:0] trial;
    logic          qbit;
    logic [W1:0]   prem_next;
    logic [W0-1:0] q_next;

    // The guard bit of the partial remainder is always 0 after a restoring step.
    logic unused_bits;
    assign unused_bits = ^{prem_q[W1], (ID != 0)};

    assign mag0 = din0[W0-1] ? -din0 : din0;
    assign mag1 = din1[W1-1] ? -din1 : din1;

    // The dividend register doubles as the quotient register: MSBs shift out, quotient bits in.
    assign shifted   = {1'b0, prem_q[W1-1:0], dvd_q[W0-1]};
    assign trial     = shifted - {2'b00, dvs_q};
    assign qbit      = ~trial[W1+1];
    assign prem_next = qbit ? trial[W1:0] : shifted[W1:0];
    assign q_next    = {dvd_q[W0-2:0], qbit};

    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        prem_d     = prem_q;
        cnt_d      = cnt_q;
        sign0_d    = sign0_q;
        sign1_d    = sign1_q;
        ovf_pend_d = ovf_pend_q;
        dout_d     = dout_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign0_d    = din0[W0-1];
                    sign1_d    = din1[W1-1];
                    dvd_d      = mag0;
                    dvs_d      = mag1;
                    prem_d     = '0;
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    ovf_pend_d = (din0 == {1'b1, {(W0-1){1'b0}}}) && (din1 == '1);
                    if (din1 == '0) begin
                        dout_d     = '1;
                        rem_d      = '0;
                        div_zero_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d   = CW'(W0);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                dvd_d  = q_next;
                prem_d = prem_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    dout_d  = (sign0_q ^ sign1_q) ? -q_next : q_next;
                    rem_d   = sign0_q ? -prem_next[W1-1:0] : prem_next[W1-1:0];
                    ovf_d   = ovf_pend_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            prem_q     <= '0;
            cnt_q      <= '0;
            sign0_q    <= 1'b0;
            sign1_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            dout_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            prem_q     <= prem_d;
            cnt_q      <= cnt_d;
            sign0_q    <= sign0_d;
            sign1_q    <= sign1_d;
            ovf_pend_q <= ovf_pend_d;
            dout_q     <= dout_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dout      = dout_q;
    assign rem       = rem_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_case_9_sdiv_10s_4s_seq.sv
// Directed bench for the sequential signed divider: latency, signs, flags,
// back-pressure, mid-operation reset, plus model-checked random operations.
module tb_case_9_sdiv_10s_4s_seq;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] din0;
    logic [3:0] din1;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] dout;
    logic [3:0] rem;
    logic       div_zero;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    case_9_sdiv_10s_4s_seq #(
        .ID(1), .din0_WIDTH(10), .din1_WIDTH(4), .dout_WIDTH(10)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .rem      (rem),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // C-semantics reference: truncating quotient, remainder takes dividend sign.
    task automatic model(input logic [9:0] a, input logic [3:0] b,
                         output logic [9:0] q, output logic [3:0] r,
                         output logic dz, output logic ov);
        int ai, bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            q  = 10'h3FF;
            r  = 4'h0;
            dz = 1'b1;
        end else if (ai == -512 && bi == -1) begin
            q  = 10'h200;
            r  = 4'h0;
            ov = 1'b1;
        end else begin
            q = 10'(ai / bi);
            r = 4'(ai % bi);
        end
    endtask

    task automatic wait_in_ready();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge ap_clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Presents one operation, checks latency and results, holds the result for
    // 'hold' cycles under back-pressure, then completes the output handshake.
    task automatic run_op(input string tag, input logic [9:0] a, input logic [3:0] b,
                          input logic [9:0] eq, input logic [3:0] er,
                          input logic edz, input logic eov, input int hold);
        int lat;
        @(negedge ap_clk);
        wait_in_ready();
        in_valid = 1'b1;
        din0     = a;
        din1     = b;
        @(negedge ap_clk);
        in_valid = 1'b0;
        din0     = ~a;
        din1     = ~b;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge ap_clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), (b == 4'h0) ? 32'd0 : 32'd10);
        repeat (hold) @(negedge ap_clk);
        check({tag, "_dout"}, 32'(dout), 32'(eq));
        check({tag, "_rem"}, 32'(rem), 32'(er));
        check({tag, "_dz"}, 32'(div_zero), 32'(edz));
        check({tag, "_ovf"}, 32'(ovf), 32'(eov));
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        check({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [9:0] ra, rq;
        logic [3:0] rb, rr;
        logic       rdz, rov;
        int         lat;

        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_flags", {30'd0, div_zero, ovf}, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Hand-computed vectors
        run_op("p100_p7",  10'h064, 4'h7, 10'h00E, 4'h2, 1'b0, 1'b0, 0);
        run_op("m100_p7",  10'h39C, 4'h7, 10'h3F2, 4'hE, 1'b0, 1'b0, 0);
        run_op("p100_m7",  10'h064, 4'h9, 10'h3F2, 4'h2, 1'b0, 1'b0, 0);
        run_op("m100_m7",  10'h39C, 4'h9, 10'h00E, 4'hE, 1'b0, 1'b0, 0);
        run_op("p511_m8",  10'h1FF, 4'h8, 10'h3C1, 4'h7, 1'b0, 1'b0, 0);
        run_op("m512_m1",  10'h200, 4'hF, 10'h200, 4'h0, 1'b0, 1'b1, 0);
        run_op("m37_z",    10'h3DB, 4'h0, 10'h3FF, 4'h0, 1'b1, 1'b0, 0);
        run_op("p100_p7b", 10'h064, 4'h7, 10'h00E, 4'h2, 1'b0, 1'b0, 0);

        // Back-pressure: result must hold while new inputs wiggle
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0     = 10'h064;
        din1     = 4'h7;
        @(negedge ap_clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge ap_clk);
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd10);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            din0     = 10'(5 + i * 3);
            din1     = 4'h3;
            @(negedge ap_clk);
            check("bp_hold_dout", 32'(dout), 32'h00E);
            check("bp_hold_rem", 32'(rem), 32'h2);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        din0      = 10'd50;
        din1      = 4'h3;
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        check("bp_hs_valid", 32'(out_valid), 32'd0);
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        @(negedge ap_clk);
        in_valid = 1'b0;
        check("bp_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge ap_clk);
            lat++;
        end
        check("bp_pend_lat", 32'(lat), 32'd10);
        check("bp_pend_dout", 32'(dout), 32'd16);
        check("bp_pend_rem", 32'(rem), 32'd2);
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;

        // Reset in the middle of CALC after the fourth iteration
        in_valid = 1'b1;
        din0     = 10'h39C;
        din1     = 4'h9;
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (4) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_rem", 32'(rem), 32'd0);
        check("mid_rst_flags", {30'd0, div_zero, ovf}, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_op("p9_p2", 10'd9, 4'd2, 10'd4, 4'd1, 1'b0, 1'b0, 0);

        // Random operations with random gaps and output stalls
        for (int k = 0; k < 300; k++) begin
            ra = 10'($urandom_range(0, 1023));
            rb = 4'($urandom_range(0, 15));
            if (k == 0) begin
                ra = 10'h200;
                rb = 4'h1;
            end
            model(ra, rb, rq, rr, rdz, rov);
            repeat ($urandom_range(0, 2)) @(negedge ap_clk);
            run_op("rnd", ra, rb, rq, rr, rdz, rov, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
